// File: rtl/race_pkg.sv
// race_pkg: shared types and constants for the lane-racing game controller.
//   race_state_t  game state encoding (IDLE/RUN/CRASH, 3 is unused)
//   lane / sprite / screen constants, LFSR seed
//   rnd_to_lane   maps two random bits onto a lane index
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2,
    ST_BAD   = 2'd3
  } race_state_t;

  localparam logic [9:0]  LANE_L_X    = 10'd197;
  localparam logic [9:0]  LANE_C_X    = 10'd279;
  localparam logic [9:0]  LANE_R_X    = 10'd361;
  localparam logic [9:0]  CAR_Y_POS   = 10'd357;
  localparam logic [9:0]  SPR_H_LINES = 10'd121;
  localparam logic [9:0]  SCREEN_H    = 10'd480;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  localparam logic [1:0] LANE_IDX_L = 2'd0;
  localparam logic [1:0] LANE_IDX_C = 2'd1;
  localparam logic [1:0] LANE_IDX_R = 2'd2;

  // Four random codes onto three lanes; the spare code favours the centre.
  function automatic logic [1:0] rnd_to_lane(input logic [1:0] rnd);
    return (rnd == 2'd3) ? LANE_IDX_C : rnd;
  endfunction

endpackage

// File: rtl/race_lfsr16.sv
// race_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
//   clk    clock, rising edge
//   reset  synchronous, active-high; loads the seed
//   value  current register contents
// The polynomial is maximal length, so a non-zero seed never reaches zero.
module race_lfsr16
  import race_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (reset) value <= LFSR_SEED;
    else       value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
  end

endmodule

// File: rtl/race_game_ctrl.sv
// race_game_ctrl: game-logic controller for a three-lane racing game.
//   vga_clk, reset          pixel clock; synchronous active-high reset
//   left, right, start      asynchronous push-buttons
//   hcount, vcount          raster position from the VGA timing block
//   car_x, car_y            car sprite origin
//   obs_x, obs_y, obs_valid obstacle sprite origin and draw enable
//   scroll_off              road-bar sprite vertical offset
//   state, score            game state and obstacles passed
//   frame_tick              one-cycle strobe once per frame (start of vblank)
// All game state changes only on frame_tick, so the sprites never move
// during active video.
module race_game_ctrl
  import race_pkg::*;
#(
  parameter int LANE_L      = int'(LANE_L_X),
  parameter int LANE_C      = int'(LANE_C_X),
  parameter int LANE_R      = int'(LANE_R_X),
  parameter int CAR_Y       = int'(CAR_Y_POS),
  parameter int SPR_H       = int'(SPR_H_LINES),
  parameter int SCROLL_STEP = 2,
  parameter int OBS_STEP    = 4
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  input  logic        start,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [9:0]  car_x,
  output logic [9:0]  car_y,
  output logic [9:0]  obs_x,
  output logic [9:0]  obs_y,
  output logic        obs_valid,
  output logic [7:0]  scroll_off,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic        frame_tick
);

  localparam logic [9:0]  LX_L         = 10'(LANE_L);
  localparam logic [9:0]  LX_C         = 10'(LANE_C);
  localparam logic [9:0]  LX_R         = 10'(LANE_R);
  localparam logic [9:0]  CAR_Y10      = 10'(CAR_Y);
  localparam logic [10:0] CAR_Y11      = 11'(CAR_Y);
  localparam logic [10:0] SPR_H11      = 11'(SPR_H);
  localparam logic [10:0] OBS_STEP11   = 11'(OBS_STEP);
  localparam logic [7:0]  SCROLL_STEP8 = 8'(SCROLL_STEP);

  function automatic logic [9:0] lane_x(input logic [1:0] idx);
    case (idx)
      LANE_IDX_L: lane_x = LX_L;
      LANE_IDX_R: lane_x = LX_R;
      default:    lane_x = LX_C;
    endcase
  endfunction

  logic [15:0] lfsr_val;
  logic        unused_lfsr;

  race_lfsr16 u_lfsr (
    .clk   (vga_clk),
    .reset (reset),
    .value (lfsr_val)
  );

  // Only the low two bits pick a lane.
  assign unused_lfsr = ^lfsr_val[15:2];

  // Button synchronisers: bit 0 left, bit 1 right, bit 2 start.
  // sync3 holds the previous synchronised left/right for edge detection.
  logic [2:0] sync1, sync2;
  logic [1:0] sync3;
  logic       rise_l, rise_r, start_s;
  logic       pend_l, pend_r;

  assign rise_l  = sync2[0] & ~sync3[0];
  assign rise_r  = sync2[1] & ~sync3[1];
  assign start_s = sync2[2];

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      pend_l <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      sync1 <= {start, right, left};
      sync2 <= sync1;
      sync3 <= sync2[1:0];
      // A press arriving on the tick itself is kept for the next frame.
      pend_l <= frame_tick ? rise_l : (pend_l | rise_l);
      pend_r <= frame_tick ? rise_r : (pend_r | rise_r);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= (hcount == 10'd0) && (vcount == SCREEN_H);
  end

  // Candidate post-tick datapath values for the RUN state.
  race_state_t cur_st, nxt_st;
  logic [9:0]  nxt_car_x, nxt_obs_x, nxt_obs_y;
  logic        nxt_valid;
  logic [7:0]  nxt_scroll;
  logic [15:0] nxt_score;
  logic [10:0] obs_y_adv;
  logic        hit;

  always_comb begin
    nxt_car_x  = car_x;
    nxt_obs_x  = obs_x;
    nxt_obs_y  = obs_y;
    nxt_valid  = obs_valid;
    nxt_scroll = scroll_off;
    nxt_score  = score;
    obs_y_adv  = {1'b0, obs_y} + OBS_STEP11;
    hit        = 1'b0;
    if (cur_st == ST_RUN) begin
      nxt_scroll = scroll_off + SCROLL_STEP8;
      if (pend_l && !pend_r) begin
        if (car_x == LX_R)      nxt_car_x = LX_C;
        else if (car_x == LX_C) nxt_car_x = LX_L;
      end else if (pend_r && !pend_l) begin
        if (car_x == LX_L)      nxt_car_x = LX_C;
        else if (car_x == LX_C) nxt_car_x = LX_R;
      end
      if (!obs_valid) begin
        nxt_valid = 1'b1;
        nxt_obs_y = '0;
        nxt_obs_x = lane_x(rnd_to_lane(lfsr_val[1:0]));
      end else if (obs_y_adv >= {1'b0, SCREEN_H}) begin
        nxt_valid = 1'b0;
        nxt_obs_y = '0;
        if (score != 16'hFFFF) nxt_score = score + 16'd1;
      end else begin
        nxt_obs_y = obs_y_adv[9:0];
      end
      // Vertical overlap of two SPR_H-tall sprites, in 11 bits so the sums
      // cannot wrap.
      hit = nxt_valid && (nxt_obs_x == nxt_car_x) &&
            (({1'b0, nxt_obs_y} + SPR_H11) > CAR_Y11) &&
            ({1'b0, nxt_obs_y} < (CAR_Y11 + SPR_H11));
    end
  end

  // FSM: state register
  always_ff @(posedge vga_clk) begin
    if (reset) cur_st <= ST_IDLE;
    else       cur_st <= nxt_st;
  end

  // FSM: next state, only ever moves on frame_tick
  always_comb begin
    nxt_st = cur_st;
    if (frame_tick) begin
      case (cur_st)
        ST_IDLE:  if (start_s) nxt_st = ST_RUN;
        ST_RUN:   if (hit)     nxt_st = ST_CRASH;
        ST_CRASH: if (start_s) nxt_st = ST_IDLE;
        default:               nxt_st = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    state = cur_st;
    car_y = CAR_Y10;
  end

  // Game datapath. Entering or sitting in IDLE parks the car in the centre
  // and clears the obstacle and score; the road scroll is left where it was.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      car_x      <= LX_C;
      obs_x      <= LX_C;
      obs_y      <= '0;
      obs_valid  <= 1'b0;
      scroll_off <= '0;
      score      <= '0;
    end else if (frame_tick) begin
      if (nxt_st == ST_IDLE) begin
        car_x     <= LX_C;
        obs_y     <= '0;
        obs_valid <= 1'b0;
        score     <= '0;
      end else begin
        car_x      <= nxt_car_x;
        obs_x      <= nxt_obs_x;
        obs_y      <= nxt_obs_y;
        obs_valid  <= nxt_valid;
        scroll_off <= nxt_scroll;
        score      <= nxt_score;
      end
    end
  end

endmodule

// File: tb/tb_race_game_ctrl.sv
// tb_race_game_ctrl: directed bench for race_game_ctrl with a cycle model
// and a scoreboard queue, driving a shortened raster (8 pixels x lines
// 476..483, 64 cycles per frame, one frame_tick per frame).
module tb_race_game_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset, left, right, start;
  logic [9:0]  hcount, vcount;
  logic [9:0]  car_x, car_y, obs_x, obs_y;
  logic        obs_valid;
  logic [7:0]  scroll_off;
  logic [1:0]  state;
  logic [15:0] score;
  logic        frame_tick;

  race_game_ctrl dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .left       (left),
    .right      (right),
    .start      (start),
    .hcount     (hcount),
    .vcount     (vcount),
    .car_x      (car_x),
    .car_y      (car_y),
    .obs_x      (obs_x),
    .obs_y      (obs_y),
    .obs_valid  (obs_valid),
    .scroll_off (scroll_off),
    .state      (state),
    .score      (score),
    .frame_tick (frame_tick)
  );

  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [67:0] sb_q[$];

  // Reference model state (lanes as indices 0=L, 1=C, 2=R).
  logic [15:0] m_lfsr;
  logic        m_tick, m_pl, m_pr, m_valid;
  logic [2:0]  m_s1, m_s2;
  logic [1:0]  m_s3, m_state;
  int          m_lane, m_obs_lane, m_obs_y, m_scroll, m_score;
  int          m_run_ticks = 0;

  function automatic logic [9:0] lx(input int l);
    return (l == 0) ? 10'd197 : (l == 2) ? 10'd361 : 10'd279;
  endfunction

  function automatic logic [67:0] m_vec();
    return {m_state, lx(m_lane), 10'd357, lx(m_obs_lane), 10'(m_obs_y),
            m_valid, 8'(m_scroll), 16'(m_score), m_tick};
  endfunction

  function automatic logic [67:0] dut_vec();
    return {state, car_x, car_y, obs_x, obs_y, obs_valid, scroll_off, score, frame_tick};
  endfunction

  task automatic frame_step();
    case (m_state)
      2'd0: if (m_s2[2]) m_state = 2'd1;
      2'd1: begin
        m_run_ticks++;
        m_scroll = (m_scroll + 2) % 256;
        if (m_pl && !m_pr && m_lane > 0)      m_lane--;
        else if (m_pr && !m_pl && m_lane < 2) m_lane++;
        if (!m_valid) begin
          m_valid    = 1'b1;
          m_obs_y    = 0;
          m_obs_lane = (m_lfsr[1:0] == 2'd3) ? 1 : int'(m_lfsr[1:0]);
        end else if (m_obs_y + 4 >= 480) begin
          m_valid = 1'b0;
          m_obs_y = 0;
          if (m_score < 65535) m_score++;
        end else begin
          m_obs_y += 4;
        end
        // Obstacle rows [y, y+121) overlap car rows [357, 478).
        if (m_valid && m_obs_lane == m_lane && m_obs_y > 236 && m_obs_y < 478)
          m_state = 2'd2;
      end
      default: if (m_s2[2]) begin
        m_state = 2'd0;
        m_lane  = 1;
        m_valid = 1'b0;
        m_obs_y = 0;
        m_score = 0;
      end
    endcase
  endtask

  // Advance the model across the coming rising edge using current inputs.
  task automatic model_edge();
    logic [1:0] rise;
    if (reset) begin
      m_lfsr = 16'hACE1; m_tick = 1'b0; m_pl = 1'b0; m_pr = 1'b0;
      m_s1 = '0; m_s2 = '0; m_s3 = '0;
      m_state = 2'd0; m_lane = 1; m_obs_lane = 1; m_obs_y = 0;
      m_valid = 1'b0; m_scroll = 0; m_score = 0;
    end else begin
      if (m_tick) frame_step();
      rise = m_s2[1:0] & ~m_s3;
      if (m_tick) begin
        m_pl = rise[0];
        m_pr = rise[1];
      end else begin
        m_pl = m_pl | rise[0];
        m_pr = m_pr | rise[1];
      end
      m_s3   = m_s2[1:0];
      m_s2   = m_s1;
      m_s1   = {start, right, left};
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
      m_tick = (hcount == 10'd0) && (vcount == 10'd480);
    end
  endtask

  task automatic cyc();
    logic [67:0] exp_v;
    model_edge();
    sb_q.push_back(m_vec());
    @(posedge vga_clk);
    @(negedge vga_clk);
    exp_v = sb_q.pop_front();
    n_cmp++;
    assert (dut_vec() === exp_v) else begin
      n_bad++;
      $error("FAIL cycle_out t=%0t observed=%h expected=%h", $time, dut_vec(), exp_v);
    end
    if (hcount == 10'd7) begin
      hcount = 10'd0;
      vcount = (vcount == 10'd483) ? 10'd476 : vcount + 10'd1;
    end else begin
      hcount = hcount + 10'd1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic run_frame(input logic l, input logic r, input logic s);
    int tk = 0;
    for (int i = 0; i < 64; i++) begin
      left  = l && (i < 8);
      right = r && (i < 8);
      start = s && (i < 40);
      cyc();
      if (frame_tick === 1'b1) tk++;
    end
    left = 1'b0; right = 1'b0; start = 1'b0;
    check("ticks_per_frame", tk, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},  state, 0);
    check({tag, "_car_x"},  car_x, 279);
    check({tag, "_car_y"},  car_y, 357);
    check({tag, "_obs_x"},  obs_x, 279);
    check({tag, "_obs_y"},  obs_y, 0);
    check({tag, "_valid"},  obs_valid, 0);
    check({tag, "_scroll"}, scroll_off, 0);
    check({tag, "_score"},  score, 0);
    check({tag, "_tick"},   frame_tick, 0);
  endtask

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; start = 1'b0;
    hcount = 10'd0; vcount = 10'd476;
    // Full frame in reset: the raster passes line 480 but no tick may occur.
    repeat (64) cyc();
    check_reset_vals("reset");
    reset = 1'b0;

    run_frame(0, 0, 0);
    run_frame(0, 0, 0);
    check("idle_state", state, 0);
    check("idle_car_x", car_x, 279);
    check("idle_valid", obs_valid, 0);
    check("idle_score", score, 0);

    run_frame(0, 0, 1);
    check("start_run", state, 1);
    run_frame(1, 0, 0);
    check("left1_car_x", car_x, 197);
    check("spawn_valid", obs_valid, 1);
    run_frame(1, 0, 0);
    check("left2_car_x", car_x, 197);
    run_frame(0, 1, 0);
    check("right_car_x", car_x, 279);
    run_frame(1, 1, 0);
    check("both_car_x", car_x, 279);

    // Keep out of the first obstacle's lane so it scrolls off the screen.
    if (m_obs_lane == m_lane) run_frame(0, 1, 0);
    for (int f = 0; f < 200 && m_run_ticks < 121 && m_state == 2'd1; f++) run_frame(0, 0, 0);
    check("pass_state", state, 1);
    check("pass_valid", obs_valid, 0);
    check("pass_obs_y", obs_y, 0);
    check("pass_score", score, 1);
    for (int f = 0; f < 20 && m_run_ticks < 127 && m_state == 2'd1; f++) run_frame(0, 0, 0);
    check("scroll_254", scroll_off, 254);
    run_frame(0, 0, 0);
    check("scroll_wrap", scroll_off, 0);
    check("respawn_valid", obs_valid, 1);

    // Steer into the new obstacle's lane and wait for the crash.
    for (int f = 0; f < 2; f++) begin
      if (m_obs_lane < m_lane)      run_frame(1, 0, 0);
      else if (m_obs_lane > m_lane) run_frame(0, 1, 0);
    end
    for (int f = 0; f < 100 && m_state == 2'd1; f++) run_frame(0, 0, 0);
    check("crash_state", state, 2);
    check("crash_obs_y", obs_y, 240);
    check("crash_score", score, 1);
    run_frame(1, 0, 0);
    run_frame(0, 1, 0);
    check("frozen_state", state, 2);
    check("frozen_obs_y", obs_y, 240);
    check("frozen_score", score, 1);
    run_frame(0, 0, 1);
    check("restart_state", state, 0);
    check("restart_car_x", car_x, 279);
    check("restart_score", score, 0);
    check("restart_valid", obs_valid, 0);

    // Reset in the middle of a line while running.
    run_frame(0, 0, 1);
    run_frame(0, 0, 0);
    run_frame(0, 0, 0);
    check("pre_reset_run", state, 1);
    repeat (20) cyc();
    reset = 1'b1;
    cyc();
    check_reset_vals("midreset");
    reset = 1'b0;
    repeat (43) cyc();
    run_frame(0, 0, 0);
    check("post_reset_idle", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/race_game_ctrl.md
RACE_GAME_CTRL -- requirements
Module: race_game_ctrl

Interface
REQ-001 Parameter LANE_L, default 197, left-lane car x origin (pixels).
REQ-002 Parameter LANE_C, default 279, centre-lane car x origin.
REQ-003 Parameter LANE_R, default 361, right-lane car x origin.
REQ-004 Parameter CAR_Y, default 357, fixed car y origin.
REQ-005 Parameter SPR_H, default 121, car/obstacle sprite height (lines).
REQ-006 Parameter SCROLL_STEP, default 2, bar scroll increment per frame.
REQ-007 Parameter OBS_STEP, default 4, obstacle y increment per frame.
REQ-008 vga_clk  input  1  pixel clock; all logic on its rising edge.
REQ-009 reset  input  1  reset, synchronous, active-high; clock vga_clk.
REQ-010 left, right, start  input  1 each  asynchronous push-buttons.
REQ-011 hcount, vcount  input  10 each  raster position from the VGA timing block.
REQ-012 car_x, car_y  output  10 each  car sprite origin.
REQ-013 obs_x, obs_y  output  10 each  obstacle sprite origin; obs_valid  output  1  obstacle drawn.
REQ-014 scroll_off  output  8  vertical offset for the bar sprite address.
REQ-015 state  output  2  game state; score  output  16  obstacles passed; frame_tick  output  1  frame strobe.

Function
REQ-016 frame_tick SHALL pulse high for exactly one cycle, one cycle after the cycle in which hcount==0 and vcount==480.
REQ-017 All positions, scroll_off, score and state transitions SHALL update only in the cycle frame_tick is high; outputs are stable during active video.
REQ-018 left/right/start SHALL pass a two-flop synchroniser; a rising edge of synchronised left/right SHALL set a sticky pending flag, cleared at the next frame_tick.
REQ-019 At frame_tick in RUN: pending left only moves car one lane left (R->C, C->L, L stays); pending right only moves one lane right; both pending -> no move.
REQ-020 FSM states IDLE=0, RUN=1, CRASH=2; encoding 3 unused and SHALL recover to IDLE at next frame_tick.
REQ-021 IDLE: car_x=LANE_C, obs_valid=0, score=0, scroll_off held; synchronised start high at frame_tick -> RUN.
REQ-022 RUN: scroll_off += SCROLL_STEP modulo 256 each frame_tick.
REQ-023 RUN, obs_valid=0 at frame_tick: spawn obs_valid=1, obs_y=0, obs_x from lfsr[1:0] (0->L, 1->C, 2->R, 3->C).
REQ-024 RUN, obs_valid=1 at frame_tick: obs_y += OBS_STEP; if result >=480, obs_valid=0, obs_y=0, score+1 saturating at 0xFFFF.
REQ-025 Collision SHALL be evaluated on the post-update values of the same frame_tick: obs_valid and obs_x==car_x and obs_y+SPR_H > CAR_Y and obs_y < CAR_Y+SPR_H -> CRASH in that cycle; 11-bit compare, no overflow.
REQ-026 CRASH: all positions, scroll_off, score frozen; synchronised start high at frame_tick -> IDLE.
REQ-027 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL advance every vga_clk cycle regardless of state; never all-zero.
REQ-028 car_y SHALL be constant CAR_Y.

Reset
REQ-029 On reset: state=IDLE, car_x=LANE_C, car_y=CAR_Y, obs_x=LANE_C, obs_y=0, obs_valid=0, scroll_off=0, score=0, frame_tick=0, pending flags=0, synchronisers=0, lfsr=16'hACE1.
REQ-030 Reset SHALL take priority over frame_tick and button events in the same cycle; reset mid-frame restarts in IDLE with no partial update.

Structure
REQ-031 Shared package race_pkg SHALL hold the state enum, lane constants, CAR_Y, SPR_H, screen height 480, LFSR seed.
REQ-032 LFSR SHALL be sub-module race_lfsr16 (clk, reset, value out 16).
REQ-033 Target 150-300 lines RTL; no ROM or VGA timing inside this block.

Verification
REQ-034 Reset, run 2 frames -> state=0, car_x=279, obs_valid=0, score=0, frame_tick one cycle wide per frame.
REQ-035 start at frame_tick, then left pulse twice across 2 frames -> car_x 279->197->197; right pulse -> 279.
REQ-036 left and right pulsed in same frame -> car_x unchanged at next frame_tick.
REQ-037 RUN 128 frames -> scroll_off wraps 254->0; obstacle not in car lane reaches obs_y>=480 -> obs_valid=0, score=1.
REQ-038 Force lfsr so obstacle spawns in car lane, no input -> state=2 when obs_y first >236, then positions frozen; start -> state=0.
REQ-039 Assert reset in RUN mid-line -> next cycle all outputs at REQ-029 values.
